// File: rtl/superscalar_regfile.sv
// superscalar_regfile
//   Multi-ported architectural register file for a dual-issue pipeline, with a
//   per-register busy scoreboard and optional same-cycle write-to-read bypass.
//   Register 0 is hardwired to zero and is never busy.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_addr0..3              read indices
//   rd_data0..3              read data (combinational)
//   rd_busy0..3              scoreboard busy for the read index (combinational)
//   wr_en0/1, wr_addr0/1,    write-back lanes; lane 1 is the younger
//   wr_data0/1               instruction and wins on an index conflict
//   set_en0/1, set_addr0/1   dispatch: mark destination register busy
//
// Parameters
//   DATA_W  register width
//   ADDR_W  index width, depth = 2**ADDR_W
//   BYPASS  1 = reads see same-cycle write data, 0 = stored value only
module superscalar_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              rd_busy0,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              rd_busy3,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              set_en0,
  input  logic              set_en1,
  input  logic [ADDR_W-1:0] set_addr0,
  input  logic [ADDR_W-1:0] set_addr1
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit USE_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  // Scoreboard next state: write-back clears, dispatch sets. Sets are applied
  // last so a new producer supersedes a completing older one.
  always_comb begin
    // NOTE: every bit gets a default first so no latch is inferred.
    busy_next = busy;
    if (wr_en0)  busy_next[wr_addr0]  = 1'b0;
    if (wr_en1)  busy_next[wr_addr1]  = 1'b0;
    if (set_en0) busy_next[set_addr0] = 1'b1;
    if (set_en1) busy_next[set_addr1] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is flops, not a RAM macro, so it can and must be
      // reset; unwritten registers have to read 0, never X.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments; when both lanes hit the same index
      // the later assignment (lane 1, the younger instruction) is the one
      // that takes effect.
      if (wr_en0 && (wr_addr0 != '0)) regs[wr_addr0] <= wr_data0;
      if (wr_en1 && (wr_addr1 != '0)) regs[wr_addr1] <= wr_data1;
      busy <= busy_next;
    end
  end

  // Read ports, gathered into packed vectors so one generate loop serves all.
  logic [3:0][ADDR_W-1:0] rd_addr_p;
  logic [3:0][DATA_W-1:0] rd_data_p;
  logic [3:0]             rd_busy_p;

  assign rd_addr_p = {rd_addr3, rd_addr2, rd_addr1, rd_addr0};

  for (genvar k = 0; k < 4; k++) begin : g_rd
    logic hit0;
    logic hit1;
    assign hit0 = wr_en0 && (wr_addr0 == rd_addr_p[k]);
    assign hit1 = wr_en1 && (wr_addr1 == rd_addr_p[k]);

    // Index 0 short-circuits everything, so a write to 0 never bypasses.
    assign rd_data_p[k] = (rd_addr_p[k] == '0)   ? '0       :
                          (USE_BYPASS && hit1)   ? wr_data1 :
                          (USE_BYPASS && hit0)   ? wr_data0 :
                                                   regs[rd_addr_p[k]];

    // A consumer that receives bypassed data sees it as ready. Same-cycle
    // sets are not reflected until the next cycle.
    assign rd_busy_p[k] = busy[rd_addr_p[k]] && !(USE_BYPASS && (hit0 || hit1));
  end

  assign rd_data0 = rd_data_p[0];
  assign rd_data1 = rd_data_p[1];
  assign rd_data2 = rd_data_p[2];
  assign rd_data3 = rd_data_p[3];
  assign rd_busy0 = rd_busy_p[0];
  assign rd_busy1 = rd_busy_p[1];
  assign rd_busy2 = rd_busy_p[2];
  assign rd_busy3 = rd_busy_p[3];

endmodule

// File: tb/tb_superscalar_regfile.sv
// tb_superscalar_regfile
//   Drives two copies of the register file (BYPASS=0 and BYPASS=1) with the
//   same inputs. Expected read data / busy values come from a behavioural
//   model, are pushed to a scoreboard queue and are popped and compared
//   against the outputs half a clock away from the rising edge.
module tb_superscalar_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][AW-1:0] ra;
  logic               we0, we1, se0, se1;
  logic [AW-1:0]      wa0, wa1, sa0, sa1;
  logic [DW-1:0]      wd0, wd1;

  // index 0: BYPASS=0 instance, index 1: BYPASS=1 instance
  logic [3:0][DW-1:0] data_n, data_b;
  logic [3:0]         busy_n, busy_b;

  superscalar_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(ra[0]), .rd_addr1(ra[1]), .rd_addr2(ra[2]), .rd_addr3(ra[3]),
    .rd_data0(data_n[0]), .rd_data1(data_n[1]), .rd_data2(data_n[2]), .rd_data3(data_n[3]),
    .rd_busy0(busy_n[0]), .rd_busy1(busy_n[1]), .rd_busy2(busy_n[2]), .rd_busy3(busy_n[3]),
    .wr_en0(we0), .wr_en1(we1), .wr_addr0(wa0), .wr_addr1(wa1),
    .wr_data0(wd0), .wr_data1(wd1),
    .set_en0(se0), .set_en1(se1), .set_addr0(sa0), .set_addr1(sa1)
  );

  superscalar_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(ra[0]), .rd_addr1(ra[1]), .rd_addr2(ra[2]), .rd_addr3(ra[3]),
    .rd_data0(data_b[0]), .rd_data1(data_b[1]), .rd_data2(data_b[2]), .rd_data3(data_b[3]),
    .rd_busy0(busy_b[0]), .rd_busy1(busy_b[1]), .rd_busy2(busy_b[2]), .rd_busy3(busy_b[3]),
    .wr_en0(we0), .wr_en1(we1), .wr_addr0(wa0), .wr_addr1(wa1),
    .wr_data0(wd0), .wr_data1(wd1),
    .set_en0(se0), .set_en1(se1), .set_addr0(sa0), .set_addr1(sa1)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Applies one rising edge worth of architectural effect.
  task automatic model_edge();
    if (we0 && wa0 != 0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[wa1] = wd1;   // younger lane overwrites
    if (we0) m_busy[wa0] = 1'b0;
    if (we1) m_busy[wa1] = 1'b0;
    if (se0) m_busy[sa0] = 1'b1;             // set supersedes clear
    if (se1) m_busy[sa1] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    logic hit;
    hit = (we0 && wa0 == a) || (we1 && wa1 == a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(byp && hit);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string         tag;
    int            inst;    // 0 = no bypass, 1 = bypass
    int            port;
    bit            is_busy;
    logic [DW-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [DW-1:0] observed(input int inst, input int port, input bit is_busy);
    if (is_busy) return (inst == 0) ? {31'b0, busy_n[port]} : {31'b0, busy_b[port]};
    return (inst == 0) ? data_n[port] : data_b[port];
  endfunction

  task automatic push_model(input string tag);
    sb_entry_t e;
    for (int inst = 0; inst < 2; inst++)
      for (int p = 0; p < 4; p++) begin
        e.tag = tag; e.inst = inst; e.port = p;
        e.is_busy = 1'b0; e.exp = exp_data(inst == 1, ra[p]);
        sb.push_back(e);
        e.is_busy = 1'b1; e.exp = {31'b0, exp_busy(inst == 1, ra[p])};
        sb.push_back(e);
      end
  endtask

  task automatic push_const(input string tag, input int inst, input int port,
                            input bit is_busy, input logic [DW-1:0] value);
    sb_entry_t e;
    e.tag = tag; e.inst = inst; e.port = port; e.is_busy = is_busy; e.exp = value;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    logic [DW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observed(e.inst, e.port, e.is_busy);
      tests_run++;
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s byp=%0d port=%0d %s: got %h expected %h", e.tag, e.inst, e.port,
               e.is_busy ? "busy" : "data", obs, e.exp);
      end
    end
  endtask

  // Sample 1 time unit after the inputs settle, mid low phase.
  task automatic check(input string tag);
    #1;
    push_model(tag);
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; se0 = 0; se1 = 0;
    wa0 = '0; wa1 = '0; sa0 = '0; sa1 = '0;
    wd0 = '0; wd1 = '0;
  endtask

  task automatic reads(input logic [AW-1:0] a0, a1, a2, a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reads(5'd1, 5'd2, 5'd3, 5'd31);
    model_reset();
    #2;
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    check("after_reset_release");

    // Write reg5 and mark reg6 busy, then assert reset mid-cycle.
    wa0 = 5'd5; wd0 = 32'hDEADBEEF; we0 = 1; se0 = 1; sa0 = 5'd6;
    tick();
    idle();
    reads(5'd5, 5'd6, 5'd5, 5'd0);
    check("pre_reset_values");
    push_const("reg5_written", 0, 0, 1'b0, 32'hDEADBEEF);
    push_const("reg6_busy", 0, 1, 1'b1, 32'h1);
    drain();
    we0 = 1; wa0 = 5'd8; wd0 = 32'h55;   // in flight when reset hits
    reads(5'd5, 5'd6, 5'd8, 5'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    check("async_reset_mid_cycle");
    push_const("reg5_cleared", 0, 0, 1'b0, 32'h0);
    drain();
    tick();
    idle();
    check("reset_discards_write");
    rst_n = 1'b1;

    // Writes and sets to register 0 are ignored.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; se0 = 1; sa0 = 5'd0;
    reads(5'd0, 5'd0, 5'd0, 5'd0);
    check("reg0_same_cycle");
    tick();
    idle();
    check("reg0_after");
    push_const("reg0_zero", 1, 2, 1'b0, 32'h0);
    drain();

    // Basic write/read: BYPASS=0 sees old value this cycle, new value next.
    we0 = 1; wa0 = 5'd2; wd0 = 32'hFFFFFFFF;
    reads(5'd2, 5'd3, 5'd2, 5'd3);
    check("write_cycle_n");
    push_const("nobyp_old", 0, 0, 1'b0, 32'h0);
    push_const("byp_new", 1, 0, 1'b0, 32'hFFFFFFFF);
    drain();
    tick();
    idle();
    check("write_cycle_n1");
    push_const("nobyp_new", 0, 2, 1'b0, 32'hFFFFFFFF);
    drain();

    // Bypass clears busy for the consumer.
    se0 = 1; sa0 = 5'd3;
    reads(5'd3, 5'd3, 5'd3, 5'd3);
    check("set_same_cycle_not_masked");
    tick();
    idle();
    check("reg3_busy");
    we0 = 1; wa0 = 5'd3; wd0 = 32'hA;
    check("bypass_reg3");
    push_const("byp_data_a", 1, 1, 1'b0, 32'hA);
    push_const("byp_ready", 1, 1, 1'b1, 32'h0);
    push_const("nobyp_still_busy", 0, 1, 1'b1, 32'h1);
    drain();
    tick();
    idle();
    check("reg3_after_write");

    // Write conflict: lane 1 wins.
    we0 = 1; wa0 = 5'd7; wd0 = 32'h1;
    we1 = 1; wa1 = 5'd7; wd1 = 32'h2;
    reads(5'd7, 5'd7, 5'd0, 5'd7);
    check("conflict_same_cycle");
    push_const("conflict_byp", 1, 0, 1'b0, 32'h2);
    drain();
    tick();
    idle();
    check("conflict_after");
    push_const("conflict_stored", 0, 0, 1'b0, 32'h2);
    drain();

    // Scoreboard: set, then write+set same index, then plain write.
    se0 = 1; sa0 = 5'd4;
    reads(5'd4, 5'd4, 5'd4, 5'd4);
    tick();
    idle();
    check("reg4_busy");
    we0 = 1; wa0 = 5'd4; wd0 = 32'h44; se1 = 1; sa1 = 5'd4;
    check("reg4_write_and_set");
    tick();
    idle();
    check("reg4_set_wins");
    push_const("reg4_still_busy", 0, 3, 1'b1, 32'h1);
    push_const("reg4_data", 1, 3, 1'b0, 32'h44);
    drain();
    we1 = 1; wa1 = 5'd4; wd1 = 32'h45;
    tick();
    idle();
    check("reg4_cleared");
    push_const("reg4_not_busy", 1, 0, 1'b1, 32'h0);
    drain();

    // Four-port aliasing.
    we0 = 1; wa0 = 5'd9; wd0 = 32'h12345678;
    tick();
    idle();
    we1 = 1; wa1 = 5'd10; wd1 = 32'hCAFEF00D;
    reads(5'd9, 5'd9, 5'd9, 5'd9);
    check("alias_all_ports");
    reads(5'd9, 5'd10, 5'd9, 5'd10);
    check("alias_with_write");
    tick();
    idle();
    check("alias_after");

    // Random traffic over a small index range to force collisions.
    for (int c = 0; c < 60; c++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      se0 = 1'($urandom_range(0, 1)); sa0 = 5'($urandom_range(0, 7));
      se1 = 1'($urandom_range(0, 1)); sa1 = 5'($urandom_range(0, 7));
      reads(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check("random");
      tick();
    end
    idle();
    for (int a = 0; a < 8; a += 4) begin
      reads(5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3));
      check("final_sweep");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
